// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read slave between NUM_M masters.
// One burst in flight at a time; the slave ARID carries the grant index.
module axi_rd_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NUM_M-1:0]        m_arvalid,
  output logic [NUM_M-1:0]        m_arready,
  input  logic [NUM_M*ADDR_W-1:0] m_araddr,
  input  logic [NUM_M*8-1:0]      m_arlen,
  output logic [DATA_W-1:0]       m_rdata,
  output logic [1:0]              m_rresp,
  output logic                    m_rlast,
  output logic [NUM_M-1:0]        m_rvalid,
  input  logic [NUM_M-1:0]        m_rready,
  output logic [ID_W-1:0]         s_arid,
  output logic [ADDR_W-1:0]       s_araddr,
  output logic [7:0]              s_arlen,
  output logic [2:0]              s_arsize,
  output logic [1:0]              s_arburst,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [ID_W-1:0]         s_rid,
  input  logic [DATA_W-1:0]       s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rlast,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  output logic                    busy,
  output logic                    id_err
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARB_AR,
    ARB_R
  } state_t;

  state_t          state, state_n;
  logic [GW-1:0]   grant, grant_n;
  logic [GW-1:0]   rr_ptr, rr_ptr_n;
  logic            id_err_n;
  logic [GW-1:0]   pick;
  logic            pick_v;
  logic [GW-1:0]   grant_inc;

  // Walk downward so the requester closest to rr_ptr is written last.
  always_comb begin
    pick   = '0;
    pick_v = 1'b0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (m_arvalid[idx]) begin
        pick   = GW'(idx);
        pick_v = 1'b1;
      end
    end
  end

  assign grant_inc = (int'(grant) == NUM_M - 1) ? '0 : grant + GW'(1);

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    rr_ptr_n  = rr_ptr;
    id_err_n  = id_err;
    s_arvalid = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    s_rready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_v) begin
          grant_n = pick;
          state_n = ARB_AR;
        end
      end
      ARB_AR: begin
        s_arvalid        = 1'b1;
        m_arready[grant] = s_arready;
        if (s_arready) state_n = ARB_R;
      end
      ARB_R: begin
        m_rvalid[grant] = s_rvalid;
        s_rready        = m_rready[grant];
        if (s_rvalid && m_rready[grant]) begin
          if (s_rid != ID_W'(grant)) id_err_n = 1'b1;
          if (s_rlast) begin
            rr_ptr_n = grant_inc;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      id_err <= 1'b0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      rr_ptr <= rr_ptr_n;
      id_err <= id_err_n;
    end
  end

  assign s_arid    = ID_W'(grant);
  assign s_araddr  = m_araddr[int'(grant)*ADDR_W +: ADDR_W];
  assign s_arlen   = m_arlen[int'(grant)*8 +: 8];
  assign s_arsize  = 3'($clog2(DATA_W / 8));
  assign s_arburst = 2'b01;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: behavioural slave, master BFMs and a
// round-robin reference model producing expected AR and R streams.
module tb_axi_rd_arbiter;

  localparam int NUM_M  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic                    aclk = 1'b0;
  logic                    areset;
  logic [NUM_M-1:0]        m_arvalid;
  logic [NUM_M-1:0]        m_arready;
  logic [NUM_M*ADDR_W-1:0] m_araddr;
  logic [NUM_M*8-1:0]      m_arlen;
  logic [DATA_W-1:0]       m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rlast;
  logic [NUM_M-1:0]        m_rvalid;
  logic [NUM_M-1:0]        m_rready;
  logic [ID_W-1:0]         s_arid;
  logic [ADDR_W-1:0]       s_araddr;
  logic [7:0]              s_arlen;
  logic [2:0]              s_arsize;
  logic [1:0]              s_arburst;
  logic                    s_arvalid;
  logic                    s_arready;
  logic [ID_W-1:0]         s_rid;
  logic [DATA_W-1:0]       s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rlast;
  logic                    s_rvalid;
  logic                    s_rready;
  logic                    busy;
  logic                    id_err;

  axi_rd_arbiter #(
    .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)
  ) dut (
    .aclk(aclk), .areset(areset),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .busy(busy), .id_err(id_err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [1:0]  m;
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     a;
    logic [7:0]      len;
  } ar_t;

  int passed = 0;
  int total  = 0;

  // master BFMs
  logic        req_v    [NUM_M];
  logic [31:0] req_addr [NUM_M];
  logic [7:0]  req_len  [NUM_M];
  int          rr_mode;
  logic        tog;

  // slave model
  logic            sl_busy, sl_vld;
  logic [31:0]     sl_addr;
  int              sl_rem, sl_beat;
  logic [ID_W-1:0] sl_id;
  int              ar_stall;
  bit              r_gaps, rid_force;

  // values captured in the settled part of each cycle
  bit              c_ar_hs, c_r_hs, c_rst;
  bit [NUM_M-1:0]  c_m_ar_hs;
  logic [31:0]     c_addr;
  logic [7:0]      c_len;
  logic [ID_W-1:0] c_id;

  int    cyc_n;
  beat_t obs_b[$], exp_b[$];
  ar_t   obs_ar[$], exp_ar[$];
  int    rl_cyc[$], arv_rise[$];
  int    rv_cnt[NUM_M];
  int    rv_multi;
  logic  prev_arv;
  int    ptr;

  function automatic bit any_req();
    bit r = 1'b0;
    for (int i = 0; i < NUM_M; i++) r |= req_v[i];
    return r;
  endfunction

  task automatic clear_obs();
    obs_b.delete(); exp_b.delete();
    obs_ar.delete(); exp_ar.delete();
    rl_cyc.delete(); arv_rise.delete();
    for (int i = 0; i < NUM_M; i++) rv_cnt[i] = 0;
  endtask

  // Reference: serve pending masters in rotating order starting at ptr.
  task automatic model_round(input bit [NUM_M-1:0] mask);
    bit [NUM_M-1:0] pend = mask;
    while (pend != 0) begin
      int g = 0;
      for (int k = 0; k < NUM_M; k++) begin
        if (pend[(ptr + k) % NUM_M]) begin
          g = (ptr + k) % NUM_M;
          break;
        end
      end
      pend[g] = 1'b0;
      exp_ar.push_back(ar_t'{ID_W'(g), req_addr[g], req_len[g]});
      for (int b = 0; b <= int'(req_len[g]); b++)
        exp_b.push_back(beat_t'{2'(g), req_addr[g] + 32'(4 * b), 2'(b),
                                (b == int'(req_len[g]))});
      ptr = (g + 1) % NUM_M;
    end
  endtask

  task automatic settle();
    for (int i = 0; i < NUM_M; i++) begin
      m_arvalid[i]                  = req_v[i];
      m_araddr[i*ADDR_W +: ADDR_W]  = req_addr[i];
      m_arlen[i*8 +: 8]             = req_len[i];
      case (rr_mode)
        0:       m_rready[i] = 1'b1;
        1:       m_rready[i] = tog;
        default: m_rready[i] = 1'($urandom_range(0, 1));
      endcase
    end
    #1;
    c_rst     = areset;
    c_ar_hs   = s_arvalid && s_arready;
    c_r_hs    = s_rvalid && s_rready;
    c_m_ar_hs = m_arvalid & m_arready;
    c_addr    = s_araddr;
    c_len     = s_arlen;
    c_id      = s_arid;
    if (c_ar_hs) obs_ar.push_back(ar_t'{s_arid, s_araddr, s_arlen});
    for (int i = 0; i < NUM_M; i++) begin
      if (m_rvalid[i]) rv_cnt[i]++;
      if (m_rvalid[i] && m_rready[i])
        obs_b.push_back(beat_t'{2'(i), m_rdata, m_rresp, m_rlast});
    end
    if ($countones(m_rvalid) > 1) rv_multi++;
    if (c_r_hs && s_rlast) rl_cyc.push_back(cyc_n);
    if (s_arvalid && !prev_arv) arv_rise.push_back(cyc_n);
    prev_arv = s_arvalid;
  endtask

  task automatic adv();
    @(posedge aclk);
    #1;
    cyc_n++;
    tog = ~tog;
    for (int i = 0; i < NUM_M; i++) if (c_m_ar_hs[i]) req_v[i] = 1'b0;
    if (c_rst) begin
      sl_busy = 1'b0;
      sl_vld  = 1'b0;
    end else begin
      if (c_r_hs) begin
        sl_vld = 1'b0;
        if (sl_rem == 0) sl_busy = 1'b0;
        else begin
          sl_rem--;
          sl_beat++;
        end
      end
      if (c_ar_hs) begin
        sl_busy = 1'b1;
        sl_vld  = 1'b0;
        sl_addr = c_addr;
        sl_rem  = int'(c_len);
        sl_beat = 0;
        sl_id   = c_id;
      end
    end
    if (ar_stall > 0) ar_stall--;
    if (sl_busy && !sl_vld) sl_vld = r_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
    s_arready = !sl_busy && (ar_stall == 0);
    s_rvalid  = sl_vld;
    s_rdata   = sl_addr + 32'(sl_beat * 4);
    s_rresp   = 2'(sl_beat);
    s_rlast   = (sl_rem == 0);
    s_rid     = rid_force ? ID_W'(3) : sl_id;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic drain(input int budget, output bit to);
    to = 1'b1;
    for (int n = 0; n < budget; n++) begin
      settle();
      if (!busy && !any_req()) begin
        adv();
        to = 1'b0;
        break;
      end
      adv();
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    cyc();
    cyc();
    settle();
    total++;
    if ({s_arvalid, m_rvalid} !== '0)
      $display("FAIL reset_valids got=%b required=0", {s_arvalid, m_rvalid});
    else passed++;
    total++;
    if ({m_arready, s_rready} !== '0)
      $display("FAIL reset_readies got=%b required=0", {m_arready, s_rready});
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b required=0", busy);
    else passed++;
    total++;
    if (id_err !== 1'b0) $display("FAIL reset_id_err got=%b required=0", id_err);
    else passed++;
    adv();
    areset = 1'b0;
    ptr = 0;
  endtask

  task automatic test_single();
    bit to;
    int nbad;
    clear_obs();
    req_addr[0] = 32'h100;
    req_len[0]  = 8'd3;
    model_round(2'b01);
    req_v[0] = 1'b1;
    settle();
    total++;
    if (s_arvalid !== 1'b0) $display("FAIL single_idle_arvalid got=%b required=0", s_arvalid);
    else passed++;
    adv();
    settle();
    total++;
    if (s_arvalid !== 1'b1) $display("FAIL single_ar_latency got=%b required=1", s_arvalid);
    else passed++;
    total++;
    if ({s_arid, s_arlen, s_araddr} !== {4'd0, 8'd3, 32'h100})
      $display("FAIL single_ar_fields got id=%0d len=%0d addr=%h required id=0 len=3 addr=100",
               s_arid, s_arlen, s_araddr);
    else passed++;
    total++;
    if ({s_arsize, s_arburst} !== {3'd2, 2'b01})
      $display("FAIL single_size_burst got=%b required=%b", {s_arsize, s_arburst}, 5'b01001);
    else passed++;
    adv();
    drain(64, to);
    total++;
    if (to) $display("FAIL single_timeout busy=%b required idle within 64 cycles", busy);
    else passed++;
    total++;
    nbad = (obs_b.size() != exp_b.size()) ? 1 : 0;
    foreach (exp_b[k]) if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nbad++;
    if (nbad != 0)
      $display("FAIL single_beats bad=%0d got=%0d beats required=%0d", nbad, obs_b.size(), exp_b.size());
    else passed++;
    total++;
    if (rv_cnt[1] != 0) $display("FAIL single_rvalid1 got=%0d cycles required=0", rv_cnt[1]);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL single_busy_end got=%b required=0", busy);
    else passed++;
  endtask

  task automatic test_contention();
    bit to;
    int nbad;
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    ptr = 0;
    clear_obs();
    req_addr[0] = 32'h1000; req_len[0] = 8'd2;
    req_addr[1] = 32'h2000; req_len[1] = 8'd1;
    model_round(2'b11);
    req_v[0] = 1'b1;
    req_v[1] = 1'b1;
    drain(100, to);
    total++;
    nbad = (to || obs_ar.size() != exp_ar.size()) ? 1 : 0;
    foreach (exp_ar[k]) if (k < obs_ar.size() && obs_ar[k] !== exp_ar[k]) nbad++;
    if (nbad != 0)
      $display("FAIL contention_ar_order bad=%0d got=%0d bursts required=%0d", nbad, obs_ar.size(), exp_ar.size());
    else passed++;
    total++;
    nbad = (obs_b.size() != exp_b.size()) ? 1 : 0;
    foreach (exp_b[k]) if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nbad++;
    if (nbad != 0)
      $display("FAIL contention_beats bad=%0d got=%0d beats required=%0d", nbad, obs_b.size(), exp_b.size());
    else passed++;
    total++;
    if (arv_rise.size() < 2 || rl_cyc.size() < 1 || arv_rise[1] - rl_cyc[0] != 2)
      $display("FAIL contention_bubble got=%0d starts, gap=%0d required gap=2",
               arv_rise.size(), (arv_rise.size() > 1 && rl_cyc.size() > 0) ? arv_rise[1] - rl_cyc[0] : -1);
    else passed++;
    clear_obs();
    model_round(2'b01);
    req_v[0] = 1'b1;
    drain(100, to);
    clear_obs();
    model_round(2'b11);
    req_v[0] = 1'b1;
    req_v[1] = 1'b1;
    drain(100, to);
    total++;
    if (to || obs_ar.size() != 2 || obs_ar[0].id !== 4'd1)
      $display("FAIL contention_rotate got first id=%0d bursts=%0d required first id=1 bursts=2",
               (obs_ar.size() > 0) ? int'(obs_ar[0].id) : -1, obs_ar.size());
    else passed++;
    total++;
    nbad = (obs_b.size() != exp_b.size()) ? 1 : 0;
    foreach (exp_b[k]) if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nbad++;
    if (nbad != 0)
      $display("FAIL contention_rotate_beats bad=%0d got=%0d required=%0d", nbad, obs_b.size(), exp_b.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    bit to = 1'b1;
    int nbad, stall = 0, mirror_bad = 0;
    clear_obs();
    ar_stall  = 6;
    s_arready = 1'b0;
    rr_mode   = 1;
    req_addr[1] = 32'h3000;
    req_len[1]  = 8'd3;
    model_round(2'b10);
    req_v[1] = 1'b1;
    for (int n = 0; n < 100; n++) begin
      settle();
      if (s_arvalid && !s_arready) stall++;
      if (busy && !s_arvalid && s_rready !== m_rready[1]) mirror_bad++;
      if ((!busy || s_arvalid) && s_rready !== 1'b0) mirror_bad++;
      if (!busy && !any_req()) begin
        adv();
        to = 1'b0;
        break;
      end
      adv();
    end
    rr_mode = 0;
    total++;
    if (stall != 5) $display("FAIL bp_ar_stall got=%0d cycles required=5", stall);
    else passed++;
    total++;
    if (to || mirror_bad != 0) $display("FAIL bp_rready_mirror got=%0d bad cycles timeout=%b required=0", mirror_bad, to);
    else passed++;
    total++;
    nbad = (obs_b.size() != exp_b.size()) ? 1 : 0;
    foreach (exp_b[k]) if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nbad++;
    if (nbad != 0)
      $display("FAIL bp_beats bad=%0d got=%0d beats required=%0d", nbad, obs_b.size(), exp_b.size());
    else passed++;
  endtask

  task automatic test_boundaries();
    bit to;
    int nbad;
    clear_obs();
    req_addr[0] = 32'h300;
    req_len[0]  = 8'd0;
    model_round(2'b01);
    req_v[0] = 1'b1;
    drain(40, to);
    total++;
    if (to || obs_b.size() != 1 || obs_b[0] !== exp_b[0])
      $display("FAIL len0_beat got=%0d beats last=%b required 1 beat with last",
               obs_b.size(), (obs_b.size() > 0) ? obs_b[0].l : 1'b0);
    else passed++;
    clear_obs();
    req_addr[1] = 32'h10000;
    req_len[1]  = 8'd255;
    model_round(2'b10);
    req_v[1] = 1'b1;
    drain(700, to);
    total++;
    if (to || obs_b.size() != 256) $display("FAIL len255_count got=%0d beats required=256", obs_b.size());
    else passed++;
    total++;
    nbad = (obs_b.size() != exp_b.size()) ? 1 : 0;
    foreach (exp_b[k]) if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nbad++;
    if (nbad != 0) $display("FAIL len255_beats bad=%0d got=%0d required=%0d", nbad, obs_b.size(), exp_b.size());
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL len255_idle got busy=%b required=0", busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit to;
    int nbad;
    clear_obs();
    req_addr[0] = 32'h400;
    req_len[0]  = 8'd7;
    req_v[0]    = 1'b1;
    to = 1'b1;
    for (int n = 0; n < 50; n++) begin
      settle();
      if (obs_b.size() >= 2) begin
        to = 1'b0;
        adv();
        break;
      end
      adv();
    end
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    ptr = 0;
    settle();
    total++;
    if (to || {s_arvalid, m_rvalid, m_arready, s_rready, busy} !== '0)
      $display("FAIL rst_mid_outputs got=%b timeout=%b required=0",
               {s_arvalid, m_rvalid, m_arready, s_rready, busy}, to);
    else passed++;
    adv();
    clear_obs();
    req_addr[1] = 32'h500;
    req_len[1]  = 8'd2;
    model_round(2'b10);
    req_v[1] = 1'b1;
    drain(60, to);
    total++;
    if (to || obs_ar.size() != 1 || obs_ar[0] !== exp_ar[0])
      $display("FAIL rst_mid_ar got=%0d bursts id=%0d required 1 burst id=1",
               obs_ar.size(), (obs_ar.size() > 0) ? int'(obs_ar[0].id) : -1);
    else passed++;
    total++;
    nbad = (obs_b.size() != exp_b.size()) ? 1 : 0;
    foreach (exp_b[k]) if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nbad++;
    if (nbad != 0) $display("FAIL rst_mid_beats bad=%0d got=%0d required=%0d", nbad, obs_b.size(), exp_b.size());
    else passed++;
  endtask

  task automatic test_id();
    bit to;
    settle();
    total++;
    if (id_err !== 1'b0) $display("FAIL id_err_before got=%b required=0", id_err);
    else passed++;
    adv();
    clear_obs();
    rid_force = 1'b1;
    req_addr[0] = 32'h600;
    req_len[0]  = 8'd1;
    model_round(2'b01);
    req_v[0] = 1'b1;
    drain(40, to);
    rid_force = 1'b0;
    total++;
    if (to || id_err !== 1'b1) $display("FAIL id_err_set got=%b timeout=%b required=1", id_err, to);
    else passed++;
    model_round(2'b10);
    req_v[1] = 1'b1;
    drain(40, to);
    total++;
    if (to || id_err !== 1'b1) $display("FAIL id_err_sticky got=%b timeout=%b required=1", id_err, to);
    else passed++;
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    ptr = 0;
    settle();
    total++;
    if (id_err !== 1'b0) $display("FAIL id_err_clear got=%b required=0", id_err);
    else passed++;
    adv();
  endtask

  task automatic test_random();
    bit to;
    int nbad;
    bit [NUM_M-1:0] mask;
    rr_mode = 2;
    r_gaps  = 1'b1;
    rv_multi = 0;
    for (int r = 0; r < 12; r++) begin
      clear_obs();
      mask = NUM_M'($urandom_range(1, (1 << NUM_M) - 1));
      for (int i = 0; i < NUM_M; i++) begin
        req_addr[i] = $urandom() & 32'hFFFF_FFF0;
        req_len[i]  = 8'($urandom_range(0, 7));
      end
      ar_stall = $urandom_range(0, 3);
      model_round(mask);
      for (int i = 0; i < NUM_M; i++) req_v[i] = mask[i];
      drain(500, to);
      total++;
      nbad = (to || obs_ar.size() != exp_ar.size()) ? 1 : 0;
      foreach (exp_ar[k]) if (k < obs_ar.size() && obs_ar[k] !== exp_ar[k]) nbad++;
      if (nbad != 0)
        $display("FAIL rand%0d_ar bad=%0d got=%0d bursts required=%0d", r, nbad, obs_ar.size(), exp_ar.size());
      else passed++;
      total++;
      nbad = (obs_b.size() != exp_b.size()) ? 1 : 0;
      foreach (exp_b[k]) if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nbad++;
      if (nbad != 0)
        $display("FAIL rand%0d_beats bad=%0d got=%0d beats required=%0d", r, nbad, obs_b.size(), exp_b.size());
      else passed++;
    end
    total++;
    if (rv_multi != 0) $display("FAIL rand_rvalid_onehot got=%0d multi-hot cycles required=0", rv_multi);
    else passed++;
    rr_mode = 0;
    r_gaps  = 1'b0;
  endtask

  initial begin
    areset    = 1'b1;
    rr_mode   = 0;
    tog       = 1'b1;
    sl_busy   = 1'b0;
    sl_vld    = 1'b0;
    sl_addr   = '0;
    sl_rem    = 0;
    sl_beat   = 0;
    sl_id     = '0;
    ar_stall  = 0;
    r_gaps    = 1'b0;
    rid_force = 1'b0;
    s_arready = 1'b1;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rlast   = 1'b0;
    s_rid     = '0;
    cyc_n     = 0;
    rv_multi  = 0;
    prev_arv  = 1'b0;
    ptr       = 0;
    for (int i = 0; i < NUM_M; i++) begin
      req_v[i]    = 1'b0;
      req_addr[i] = '0;
      req_len[i]  = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_boundaries();
    test_reset_mid();
    test_id();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within 20000 cycles");
    $fatal(1);
  end

endmodule
